settings_bus_rr_arbiter: RTL and testbench
==========================================

Name: settings_bus_rr_arbiter

Overview:
Shares one downstream settings-bus resource between NUM_BUSES per-channel settings buses. Typical downstream resources are the shared timekeeper and shared front-end control.
- Each requester gets a small per-channel FIFO, so strobes arriving in the same cycle are never silently merged.
- A round-robin scheduler drains the FIFOs one write per cycle when the downstream is ready.
- Sits between the noc_shell per-channel set_* outputs and the shared-resource settings inputs in the radio core. It replaces fixed-priority muxing.

Parameters:
NUM_BUSES, 2, number of requesting settings buses (1..8)
AWIDTH, 8, settings address width
DWIDTH, 32, settings data width
FIFO_SIZE, 2, log2 of per-bus FIFO depth (depth = 2^FIFO_SIZE, ≥1)

Ports:
clk  input  1  clock (ce_clk domain)
reset_n  input  1  synchronous active-low reset
clear  input  1  synchronous flush, active-high
in_set_stb  input  NUM_BUSES  per-bus write strobe
in_set_addr  input  NUM_BUSES*AWIDTH  per-bus address, bus i at [AWIDTH*i +: AWIDTH]
in_set_data  input  NUM_BUSES*DWIDTH  per-bus data, bus i at [DWIDTH*i +: DWIDTH]
in_full  output  NUM_BUSES  per-bus FIFO full (registered)
overflow  output  NUM_BUSES  sticky: a strobe on bus i was dropped
out_set_stb  output  1  downstream write strobe, one cycle per transaction
out_set_addr  output  AWIDTH  downstream address
out_set_data  output  DWIDTH  downstream data
out_set_src  output  max(1,$clog2(NUM_BUSES))  index of the bus that issued the write
out_ready  input  1  downstream can accept a grant this cycle

Behaviour:
Clocking and reset:
- Single clock domain. Reset (reset_n==0 sampled at the clk edge) and clear behave identically.
- Both empty all FIFOs, clear overflow, and set last_grant=NUM_BUSES-1 so bus 0 is served first.
- Both force out_set_stb/addr/data/src and in_full to 0 on the next edge.
- reset_n has priority over clear. Any in-flight entries are discarded; there is no partial issue.

Enqueue:
- Bus i accepts in_set_stb[i] when count_i < depth, or when bus i is popped in the same cycle (simultaneous push/pop at full is legal).
- Otherwise the write is dropped and overflow[i] is set on the next edge. It stays set until reset or clear.
- Per-bus write order is preserved.

Scheduling (grant stage, combinational select, registered output):
- On any cycle with out_ready==1 and at least one non-empty FIFO, pick the first non-empty bus scanning last_grant+1, last_grant+2, … modulo NUM_BUSES.
- The picked bus is popped, and last_grant takes its index.
- On the next edge: out_set_stb=1, and addr/data/src come from the popped entry.
- When out_ready==0 or all FIFOs are empty, out_set_stb=0 next cycle. addr/data/src hold their previous values.

Timing:
- Latency: strobe at edge t, entry visible at t+1, granted in cycle t+1 if out_ready, out_set_stb high after edge t+2. Minimum latency is 2 cycles.
- Throughput: one write per cycle with out_ready held high. No bubbles between back-to-back grants.

Fairness and sizing:
- Fairness: with all buses backlogged, the issue order is strictly 0,1,…,N-1,0,…
- NUM_BUSES==1 degenerates to a FIFO plus output register; out_set_src=0.

in_full[i]:
- Registered: equals (count_i==depth) after the edge.
- Upstream may use it for throttling. noc_shell ignores it, which is why overflow exists.

Decomposition:
- Shared package/header (settings_bus_arb.vh): localparams for SRC_W = max(1,clog2(NUM_BUSES)) and the packed FIFO entry width AWIDTH+DWIDTH.
- One natural sub-module: settings_req_fifo.
  - Synchronous flop FIFO, width AWIDTH+DWIDTH, depth 2^FIFO_SIZE.
  - Ports: push/pop/empty/full/count, clear.
  - Reset is active-low synchronous, identical polarity to the top.
  - Instantiated NUM_BUSES times in a generate loop.
- Round-robin select stays in the top-level.

Test Plan:
1. Single write latency: NUM_BUSES=2, out_ready=1, bus1 strobes addr 0x10 data 0xDEADBEEF at edge t -> out_set_stb=1 after edge t+2 with addr 0x10, data 0xDEADBEEF, src=1. No other strobes follow.
2. Round-robin: NUM_BUSES=3, all three buses strobe 2 writes each (data 0xA0+i*2+k) on consecutive cycles, out_ready=1 -> output order src 0,1,2,0,1,2 with data A0,A2,A4,A1,A3,A5. Six consecutive strobes, no gaps.
3. Backpressure/overflow: FIFO_SIZE=2, out_ready=0, bus0 strobes 5 times -> in_full[0]=1 after the 4th, overflow[0]=1 after the 5th. Raise out_ready -> exactly 4 writes, in order.
4. Push at full with simultaneous pop: bus0 full, out_ready=1 and a new bus0 strobe in the grant cycle -> no overflow. All 5 writes eventually issued in order.
5. Reset mid-operation: with 3 entries queued and out_ready toggling, drive reset_n=0 for one cycle -> out_set_stb=0, in_full=0, overflow=0 next cycle. No queued entry ever appears afterwards, and the next grant goes to bus 0.
6. clear: same as test 5 via clear=1 with reset_n=1 -> identical result. Then verify normal operation resumes with 2-cycle latency.

Source files
------------

// File: rtl/settings_bus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// settings_bus_rr_arbiter_pkg
// Shared sizing helpers for the settings-bus round-robin arbiter and its
// per-bus request FIFO.
//   src_width()   : width of a bus index, never less than one bit
//   entry_width() : packed FIFO entry width, {addr, data}
// -----------------------------------------------------------------------------
package settings_bus_rr_arbiter_pkg;

  localparam int MAX_BUSES = 8;

  function automatic int src_width(input int num_buses);
    return (num_buses > 1) ? $clog2(num_buses) : 1;
  endfunction

  function automatic int entry_width(input int awidth, input int dwidth);
    return awidth + dwidth;
  endfunction

endpackage : settings_bus_rr_arbiter_pkg

// File: rtl/settings_req_fifo.sv
// -----------------------------------------------------------------------------
// settings_req_fifo
// Synchronous flop FIFO holding pending settings writes for one requester.
// Depth is 2**FIFO_SIZE. A push while full is accepted only if a pop happens
// in the same cycle, so a full FIFO can still stream at one write per cycle.
// Ports:
//   clk, reset_n     : clock, synchronous active-low reset
//   clear            : synchronous flush, active-high
//   push, push_data  : write request and entry
//   pop, pop_data    : read request and head entry (valid when !empty)
//   empty, full      : occupancy flags
//   count            : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module settings_req_fifo
  import settings_bus_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 40,
  parameter int FIFO_SIZE = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_SIZE:0] count
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int PTR_W = (FIFO_SIZE > 0) ? FIFO_SIZE : 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_SIZE:0] count_q, count_d;
  logic               do_push, do_pop;

  // Explicit wrap keeps depth-1 FIFOs (FIFO_SIZE == 0) correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == (FIFO_SIZE+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : settings_req_fifo

// File: rtl/settings_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// settings_bus_rr_arbiter
// Shares one downstream settings bus between NUM_BUSES requesters. Each
// requester is buffered in its own FIFO; a round-robin scheduler drains one
// write per cycle while out_ready is high, starting after the last bus served.
// Ports:
//   clk, reset_n, clear      : clock, sync active-low reset, sync flush
//   in_set_stb/addr/data     : per-bus settings writes (bus i at slice i)
//   in_full                  : per-bus FIFO full
//   overflow                 : sticky per-bus dropped-strobe flag
//   out_set_stb/addr/data    : registered downstream write
//   out_set_src              : index of the bus that issued the write
//   out_ready                : downstream accepts a grant this cycle
// -----------------------------------------------------------------------------
module settings_bus_rr_arbiter
  import settings_bus_rr_arbiter_pkg::*;
#(
  parameter  int NUM_BUSES = 2,
  parameter  int AWIDTH    = 8,
  parameter  int DWIDTH    = 32,
  parameter  int FIFO_SIZE = 2,
  localparam int SRC_W     = src_width(NUM_BUSES),
  localparam int ENTRY_W   = entry_width(AWIDTH, DWIDTH)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic [NUM_BUSES-1:0]        in_set_stb,
  input  logic [NUM_BUSES*AWIDTH-1:0] in_set_addr,
  input  logic [NUM_BUSES*DWIDTH-1:0] in_set_data,
  output logic [NUM_BUSES-1:0]        in_full,
  output logic [NUM_BUSES-1:0]        overflow,
  output logic                        out_set_stb,
  output logic [AWIDTH-1:0]           out_set_addr,
  output logic [DWIDTH-1:0]           out_set_data,
  output logic [SRC_W-1:0]            out_set_src,
  input  logic                        out_ready
);

  localparam int DEPTH = 1 << FIFO_SIZE;

  logic [ENTRY_W-1:0]   fifo_rdata [NUM_BUSES];
  logic [FIFO_SIZE:0]   fifo_count [NUM_BUSES];
  logic [NUM_BUSES-1:0] fifo_empty, fifo_full, pop;

  logic                 grant_valid;
  logic [SRC_W-1:0]     grant_idx;

  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [NUM_BUSES-1:0] overflow_q, overflow_d;
  logic                 out_stb_q, out_stb_d;
  logic [AWIDTH-1:0]    out_addr_q, out_addr_d;
  logic [DWIDTH-1:0]    out_data_q, out_data_d;
  logic [SRC_W-1:0]     out_src_q, out_src_d;

  for (genvar i = 0; i < NUM_BUSES; i++) begin : g_fifo
    settings_req_fifo #(
      .WIDTH     (ENTRY_W),
      .FIFO_SIZE (FIFO_SIZE)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .push      (in_set_stb[i]),
      .push_data ({in_set_addr[AWIDTH*i +: AWIDTH], in_set_data[DWIDTH*i +: DWIDTH]}),
      .pop       (pop[i]),
      .pop_data  (fifo_rdata[i]),
      .empty     (fifo_empty[i]),
      .full      (fifo_full[i]),
      .count     (fifo_count[i])
    );
    assign in_full[i] = (fifo_count[i] == (FIFO_SIZE+1)'(DEPTH));
  end

  // Round-robin pick: first non-empty bus after last_grant_q, wrapping.
  always_comb begin : rr_select
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (out_ready) begin
      for (int k = 1; k <= NUM_BUSES; k++) begin
        idx = int'(last_grant_q) + k;
        if (idx >= NUM_BUSES) idx = idx - NUM_BUSES;
        if (!grant_valid && !fifo_empty[SRC_W'(idx)]) begin
          grant_valid = 1'b1;
          grant_idx   = SRC_W'(idx);
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    out_stb_d    = 1'b0;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    // A strobe is dropped only when its FIFO is full and not draining this cycle.
    overflow_d   = overflow_q | (in_set_stb & fifo_full & ~pop);
    if (clear) begin
      last_grant_d = SRC_W'(NUM_BUSES - 1);
      out_addr_d   = '0;
      out_data_d   = '0;
      out_src_d    = '0;
      overflow_d   = '0;
    end else if (grant_valid) begin
      last_grant_d = grant_idx;
      out_stb_d    = 1'b1;
      {out_addr_d, out_data_d} = fifo_rdata[grant_idx];
      out_src_d    = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= SRC_W'(NUM_BUSES - 1);
      overflow_q   <= '0;
      out_stb_q    <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      out_stb_q    <= out_stb_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
    end
  end

  assign overflow     = overflow_q;
  assign out_set_stb  = out_stb_q;
  assign out_set_addr = out_addr_q;
  assign out_set_data = out_data_q;
  assign out_set_src  = out_src_q;

endmodule : settings_bus_rr_arbiter

// File: tb/tb_settings_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_settings_bus_rr_arbiter
// Scoreboard bench: a queue-based reference model runs on the rising edge and
// pushes each predicted downstream write into exp_q; a monitor on the falling
// edge pops and compares, and also checks in_full, overflow and output hold.
// Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_settings_bus_rr_arbiter;

  localparam int NB    = 3;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int FS    = 2;
  localparam int DEPTH = 1 << FS;
  localparam int SW    = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    wr_t w;
    int  cyc;
  } obs_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clear;
  logic [NB-1:0]     in_set_stb;
  logic [NB*AW-1:0]  in_set_addr;
  logic [NB*DW-1:0]  in_set_data;
  logic [NB-1:0]     in_full;
  logic [NB-1:0]     overflow;
  logic              out_set_stb;
  logic [AW-1:0]     out_set_addr;
  logic [DW-1:0]     out_set_data;
  logic [SW-1:0]     out_set_src;
  logic              out_ready;

  settings_bus_rr_arbiter #(
    .NUM_BUSES (NB),
    .AWIDTH    (AW),
    .DWIDTH    (DW),
    .FIFO_SIZE (FS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_set_stb   (in_set_stb),
    .in_set_addr  (in_set_addr),
    .in_set_data  (in_set_data),
    .in_full      (in_full),
    .overflow     (overflow),
    .out_set_stb  (out_set_stb),
    .out_set_addr (out_set_addr),
    .out_set_data (out_set_data),
    .out_set_src  (out_set_src),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [AW+DW-1:0] mq [NB][$];
  wr_t              exp_q [$];
  logic [NB-1:0]    ovf_m;
  int               lg_m;
  wr_t              hold_m;
  bit               mon_en = 1'b0;
  obs_t             issued [$];

  always @(posedge clk) begin
    cyc++;
    if (!reset_n || clear) begin
      for (int b = 0; b < NB; b++) mq[b].delete();
      exp_q.delete();
      ovf_m  = '0;
      lg_m   = NB - 1;
      hold_m = '0;
      mon_en = 1'b1;
    end else begin
      int  pick;
      wr_t w;
      pick = -1;
      if (out_ready) begin
        for (int k = 1; k <= NB; k++) begin
          int b;
          b = (lg_m + k) % NB;
          if (pick < 0 && mq[b].size() > 0) pick = b;
        end
      end
      if (pick >= 0) begin
        w.src = SW'(pick);
        {w.addr, w.data} = mq[pick].pop_front();
        lg_m   = pick;
        hold_m = w;
        exp_q.push_back(w);
      end
      // A pop above has already freed a slot, which covers push-at-full.
      for (int b = 0; b < NB; b++) begin
        if (in_set_stb[b]) begin
          if (mq[b].size() < DEPTH)
            mq[b].push_back({in_set_addr[AW*b +: AW], in_set_data[DW*b +: DW]});
          else
            ovf_m[b] = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [NB-1:0] full_m;
      for (int b = 0; b < NB; b++) full_m[b] = (mq[b].size() == DEPTH);
      check("in_full", 64'(in_full), 64'(full_m));
      check("overflow", 64'(overflow), 64'(ovf_m));
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("out_stb", 64'(out_set_stb), 64'd1);
        check("out_addr", 64'(out_set_addr), 64'(e.addr));
        check("out_data", 64'(out_set_data), 64'(e.data));
        check("out_src", 64'(out_set_src), 64'(e.src));
      end else begin
        check("out_stb_idle", 64'(out_set_stb), 64'd0);
        check("hold_addr", 64'(out_set_addr), 64'(hold_m.addr));
        check("hold_data", 64'(out_set_data), 64'(hold_m.data));
        check("hold_src", 64'(out_set_src), 64'(hold_m.src));
      end
      if (out_set_stb === 1'b1) begin
        obs_t o;
        o.w   = '{src: out_set_src, addr: out_set_addr, data: out_set_data};
        o.cyc = cyc;
        issued.push_back(o);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_bus(input int b, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_set_stb[b]          = 1'b1;
    in_set_addr[AW*b +: AW] = a;
    in_set_data[DW*b +: DW] = d;
  endtask

  task automatic do_reset();
    in_set_stb = '0;
    clear      = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n    = 1'b1;
    issued.delete();
  endtask

  task automatic check_issued_data(input string name, input int n, input logic [DW-1:0] base);
    check({name, "_count"}, 64'(issued.size()), 64'(n));
    if (issued.size() == n) begin
      for (int j = 0; j < n; j++)
        check({name, "_data"}, 64'(issued[j].w.data), 64'(base + DW'(j)));
    end
  endtask

  // Reset or clear with entries queued and out_ready toggling.
  task automatic mid_flush(input bit use_clear, input string name);
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_set_stb = '0;
      set_bus(2, 8'h50, 32'h500 + k);
      tick();
    end
    in_set_stb = '0;
    set_bus(1, 8'h51, 32'h510);
    tick();
    for (int k = 0; k < 3; k++) begin
      in_set_stb = '0;
      set_bus(0, 8'h52, 32'h520 + k);
      out_ready  = k[0];
      tick();
    end
    in_set_stb = '0;
    check({name, "_pre_ovf"}, 64'(overflow[2]), 64'd1);
    if (use_clear) clear = 1'b1; else reset_n = 1'b0;
    out_ready = 1'b1;
    tick();
    clear   = 1'b0;
    reset_n = 1'b1;
    check({name, "_stb"}, 64'(out_set_stb), 64'd0);
    check({name, "_full"}, 64'(in_full), 64'd0);
    check({name, "_ovf"}, 64'(overflow), 64'd0);
    issued.delete();
    repeat (6) tick();
    check({name, "_no_stale"}, 64'(issued.size()), 64'd0);
    set_bus(1, 8'h61, 32'h610);
    set_bus(0, 8'h60, 32'h600);
    tick();
    in_set_stb = '0;
    repeat (4) tick();
    check({name, "_after_count"}, 64'(issued.size()), 64'd2);
    if (issued.size() == 2) begin
      check({name, "_first_src"}, 64'(issued[0].w.src), 64'd0);
      check({name, "_second_src"}, 64'(issued[1].w.src), 64'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    out_ready   = 1'b0;
    in_set_stb  = '0;
    in_set_addr = '0;
    in_set_data = '0;
    tick();
    reset_n = 1'b1;

    // 1. Single write latency.
    do_reset();
    out_ready = 1'b1;
    set_bus(1, 8'h10, 32'hDEADBEEF);
    tick();
    in_set_stb = '0;
    check("t1_stb_early", 64'(out_set_stb), 64'd0);
    tick();
    check("t1_stb", 64'(out_set_stb), 64'd1);
    check("t1_addr", 64'(out_set_addr), 64'h10);
    check("t1_data", 64'(out_set_data), 64'hDEADBEEF);
    check("t1_src", 64'(out_set_src), 64'd1);
    tick();
    check("t1_stb_once", 64'(out_set_stb), 64'd0);

    // 2. Round-robin across three backlogged buses.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < NB; b++) set_bus(b, AW'(8'h20 + b), DW'(32'hA0 + b * 2 + k));
      tick();
    end
    in_set_stb = '0;
    repeat (8) tick();
    check("t2_count", 64'(issued.size()), 64'd6);
    if (issued.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        check("t2_src", 64'(issued[j].w.src), 64'(j % 3));
        check("t2_data", 64'(issued[j].w.data), 64'(32'hA0 + (j % 3) * 2 + j / 3));
        check("t2_no_gap", 64'(issued[j].cyc - issued[0].cyc), 64'(j));
      end
    end

    // 3. Backpressure and overflow.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_set_stb = '0;
      set_bus(0, 8'h30, 32'h300 + k);
      tick();
      if (k == 3) begin
        check("t3_full_after4", 64'(in_full[0]), 64'd1);
        check("t3_no_ovf_after4", 64'(overflow[0]), 64'd0);
      end
    end
    in_set_stb = '0;
    check("t3_ovf_after5", 64'(overflow[0]), 64'd1);
    out_ready = 1'b1;
    repeat (8) tick();
    check_issued_data("t3", 4, 32'h300);
    check("t3_ovf_sticky", 64'(overflow[0]), 64'd1);

    // 4. Push at full with a simultaneous pop.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_set_stb = '0;
      set_bus(0, 8'h40, 32'h400 + k);
      tick();
    end
    check("t4_full", 64'(in_full[0]), 64'd1);
    set_bus(0, 8'h40, 32'h404);
    out_ready = 1'b1;
    tick();
    in_set_stb = '0;
    check("t4_no_ovf", 64'(overflow[0]), 64'd0);
    repeat (8) tick();
    check_issued_data("t4", 5, 32'h400);

    // 5 and 6. Reset and clear mid-operation.
    mid_flush(1'b0, "t5");
    mid_flush(1'b1, "t6");
    out_ready = 1'b1;
    set_bus(2, 8'h70, 32'h700);
    tick();
    in_set_stb = '0;
    tick();
    check("t6_lat_stb", 64'(out_set_stb), 64'd1);
    check("t6_lat_src", 64'(out_set_src), 64'd2);

    // Randomized phase against the model.
    for (int n = 0; n < 1500; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      for (int b = 0; b < NB; b++) begin
        in_set_stb[b]           = $urandom_range(0, 1) == 1;
        in_set_addr[AW*b +: AW] = AW'($urandom);
        in_set_data[DW*b +: DW] = $urandom;
      end
      clear   = ($urandom_range(0, 59) == 0);
      reset_n = !($urandom_range(0, 149) == 0);
      tick();
    end
    in_set_stb = '0;
    clear      = 1'b0;
    reset_n    = 1'b1;
    out_ready  = 1'b1;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_settings_bus_rr_arbiter
